// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer for a pipeline stage register. MAIN drives the outputs and SKID absorbs
// one entry of overflow, so in_ready is a flop and has no combinational path from out_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The state is encoded as {skid_valid, main_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload registers are zeroed on reset so the outputs read all-zero afterwards.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      main_ctrl  <= '0;
      main_rd    <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_rd    <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case ({skid_valid, main_valid})
        ST_EMPTY: begin
          if (accept) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_rd    <= in_rd;
            main_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_ctrl <= in_ctrl;
            main_rd   <= in_rd;
            main_data <= in_data;
          end else if (consume) begin
            main_valid <= 1'b0;
          end else if (accept) begin
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
            skid_ctrl  <= in_ctrl;
            skid_rd    <= in_rd;
            skid_data  <= in_data;
          end
        end
        ST_FULL: begin
          if (consume) begin
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            main_ctrl  <= skid_ctrl;
            main_rd    <= skid_rd;
            main_data  <= skid_data;
          end
        end
        default: begin
          // SKID without MAIN is unreachable; recover to EMPTY.
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_rd    = main_rd;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed checks of the default-width buffer plus random traffic on a narrow instance
// compared against a queue model.
module tb_pipe_stage_buf;

  logic         clk, rst, flush;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_ctrl, out_ctrl;
  logic [4:0]   in_rd, out_rd;
  logic [127:0] in_data, out_data;
  logic [1:0]   occupancy;

  logic         w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [1:0]   w_in_ctrl, w_out_ctrl, w_occupancy;
  logic [5:0]   w_in_rd, w_out_rd;
  logic [63:0]  w_in_data, w_out_data;

  int errors = 0;
  int checks = 0;

  pipe_stage_buf u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(2), .RD_W(6)) u_dut_w (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_ctrl(w_in_ctrl), .in_rd(w_in_rd), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_ctrl(w_out_ctrl), .out_rd(w_out_rd), .out_data(w_out_data),
    .occupancy(w_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] r, input logic [127:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_rd    = r;
    in_data  = d;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [127:0] d,
                         input logic [1:0] occ, input logic rdy);
    chk({tag, "_valid"}, 128'(out_valid), 128'(v));
    if (v) chk({tag, "_data"}, out_data, d);
    chk({tag, "_occ"}, 128'(occupancy), 128'(occ));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(rdy));
  endtask

  logic [63:0] model_q[$];
  logic [63:0] next_word;
  logic        w_acc, w_con;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'h0, 5'h0, 128'h0);
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    w_in_ctrl = '0; w_in_rd = '0; w_in_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_rd", 128'(out_rd), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Streaming: each word appears one cycle after it is presented
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'h5, 5'(i), 128'(i));
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, 128'(i), 2'd1, 1'b1);
      chk("stream_rd", 128'(out_rd), 128'(i));
      chk("stream_ctrl", 128'(out_ctrl), 128'(4'h5));
    end
    drive(1'b0, 4'h0, 5'h0, 128'h0);
    tick();
    chk_out("stream_drain", 1'b0, 128'h0, 2'd0, 1'b1);

    // Backpressure: A in MAIN, B in SKID, C held off until space frees
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 5'd10, 128'hA);
    tick();
    chk_out("bp_a", 1'b1, 128'hA, 2'd1, 1'b1);
    drive(1'b1, 4'h2, 5'd11, 128'hB);
    tick();
    chk_out("bp_b_skid", 1'b1, 128'hA, 2'd2, 1'b0);
    drive(1'b1, 4'h3, 5'd12, 128'hC);
    tick();
    chk_out("bp_c_held", 1'b1, 128'hA, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("bp_out_b", 1'b1, 128'hB, 2'd1, 1'b1);
    chk("bp_out_b_rd", 128'(out_rd), 128'(11));
    tick();
    chk_out("bp_out_c", 1'b1, 128'hC, 2'd1, 1'b1);
    chk("bp_out_c_ctrl", 128'(out_ctrl), 128'(4'h3));
    drive(1'b0, 4'h0, 5'h0, 128'h0);
    tick();
    chk_out("bp_drain", 1'b0, 128'h0, 2'd0, 1'b1);

    // Flush while FULL with an incoming entry
    out_ready = 1'b0;
    drive(1'b1, 4'hF, 5'd1, 128'h11);
    tick();
    drive(1'b1, 4'hF, 5'd2, 128'h22);
    tick();
    chk_out("fl_full", 1'b1, 128'h11, 2'd2, 1'b0);
    flush = 1'b1;
    drive(1'b1, 4'hF, 5'd3, 128'hEE);
    tick();
    flush = 1'b0;
    chk_out("fl_after", 1'b0, 128'h0, 2'd0, 1'b1);
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    drive(1'b0, 4'hF, 5'd3, 128'hEE);
    out_ready = 1'b1;
    tick();
    chk_out("fl_never_out", 1'b0, 128'h0, 2'd0, 1'b1);

    // Bubble gating: stale ctrl in MAIN must not leak once MAIN is empty
    drive(1'b1, 4'hF, 5'd4, 128'h44);
    tick();
    chk("bub_live_ctrl", 128'(out_ctrl), 128'(4'hF));
    drive(1'b0, 4'hF, 5'd4, 128'h44);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_ctrl", 128'(out_ctrl), 128'(0));
      chk("bub_valid", 128'(out_valid), 128'(0));
    end

    // Reset while FULL, then a fresh transfer
    out_ready = 1'b0;
    drive(1'b1, 4'h7, 5'd5, 128'h55);
    tick();
    drive(1'b1, 4'h7, 5'd6, 128'h66);
    tick();
    chk_out("rf_full", 1'b1, 128'h55, 2'd2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 5'h0, 128'h0);
    chk("rf_valid", 128'(out_valid), 128'(0));
    chk("rf_ctrl", 128'(out_ctrl), 128'(0));
    chk("rf_rd", 128'(out_rd), 128'(0));
    chk("rf_data", out_data, 128'(0));
    chk("rf_occ", 128'(occupancy), 128'(0));
    chk("rf_in_ready", 128'(in_ready), 128'(1));
    drive(1'b1, 4'h9, 5'd13, 128'hD);
    tick();
    drive(1'b0, 4'h0, 5'h0, 128'h0);
    chk_out("rf_d", 1'b1, 128'hD, 2'd1, 1'b1);
    chk("rf_d_rd", 128'(out_rd), 128'(13));

    // Narrow instance: random valid/ready traffic against a FIFO model
    next_word = 64'h1000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      w_in_valid  = 1'($urandom_range(0, 1));
      w_out_ready = 1'($urandom_range(0, 1));
      w_in_data   = next_word;
      w_in_rd     = next_word[5:0];
      w_in_ctrl   = next_word[1:0];
      chk("w_in_ready", 128'(w_in_ready), 128'(model_q.size() < 2));
      chk("w_occ", 128'(w_occupancy), 128'(model_q.size()));
      chk("w_valid", 128'(w_out_valid), 128'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        chk("w_data", 128'(w_out_data), 128'(model_q[0]));
        chk("w_rd", 128'(w_out_rd), 128'(model_q[0][5:0]));
        chk("w_ctrl", 128'(w_out_ctrl), 128'(model_q[0][1:0]));
      end else begin
        chk("w_ctrl_bubble", 128'(w_out_ctrl), 128'(0));
      end
      w_acc = w_in_valid && (model_q.size() < 2);
      w_con = w_out_ready && (model_q.size() > 0);
      if (w_con) void'(model_q.pop_front());
      if (w_acc) begin
        model_q.push_back(next_word);
        next_word = next_word + 64'h0001_0000_0000_0003;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 128: width of the datapath payload, for example ALU result plus store data.
REQ-002 Parameter CTRL_W, default 4: width of the control-bit bundle, for example RegWrite, MemtoReg, MemWrite, MemRead.
REQ-003 Parameter RD_W, default 5: width of the destination-register index.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset; synchronous, active-high.
REQ-006 Port flush, input, 1: discard all held and incoming entries.
REQ-007 Port in_valid, input, 1: upstream presents an entry.
REQ-008 Port in_ready, output, 1: the block can accept an entry this cycle.
REQ-009 Port in_ctrl, input, CTRL_W: incoming control bits.
REQ-010 Port in_rd, input, RD_W: incoming destination register.
REQ-011 Port in_data, input, DATA_W: incoming payload.
REQ-012 Port out_valid, output, 1: an entry is presented downstream.
REQ-013 Port out_ready, input, 1: downstream consumes the entry this cycle.
REQ-014 Port out_ctrl, output, CTRL_W: presented control bits.
REQ-015 Port out_rd, output, RD_W: presented destination register.
REQ-016 Port out_data, output, DATA_W: presented payload.
REQ-017 Port occupancy, output, 2 bits: number of held entries, 0 to 2.

Function
REQ-018 The block SHALL hold two entries: MAIN, which drives the outputs, and SKID, which is overflow; each entry has its own valid bit.
REQ-019 in_ready SHALL equal NOT skid_valid and SHALL be a register output with no combinational path from out_ready.
REQ-020 An entry is accepted in a cycle when in_valid=1 and in_ready=1; an entry is consumed in a cycle when out_valid=1 and out_ready=1.
REQ-021 out_valid SHALL equal main_valid; out_rd and out_data SHALL come directly from the MAIN registers.
REQ-022 out_ctrl SHALL be the MAIN control bits ANDed with main_valid, so a bubble never presents asserted control bits.
REQ-023 The state and transitions SHALL be as follows, with S = skid_valid and M = main_valid:
- EMPTY (M=0, S=0): accept -> MAIN, go to ONE.
- ONE (M=1, S=0), consume and no accept -> EMPTY.
- ONE, accept and consume -> new entry into MAIN, stay in ONE.
- ONE, accept and no consume -> new entry into SKID, go to FULL.
- ONE, neither accept nor consume -> hold.
- FULL (M=1, S=1): accept is impossible; consume -> SKID moves into MAIN, SKID is cleared, go to ONE; no consume -> hold.
REQ-024 Latency SHALL be one cycle: an entry accepted at edge N is visible at the outputs after edge N when MAIN was empty or consumed at edge N.
REQ-025 Entries SHALL leave in acceptance order; none SHALL be duplicated or lost except by flush or rst.
REQ-026 flush=1 at an edge SHALL clear main_valid and skid_valid and discard any entry accepted in the same cycle; the state after that edge is EMPTY.
REQ-027 flush SHALL take priority over accept and consume; a consume handshake in the flush cycle is still valid for downstream.
REQ-028 occupancy SHALL equal main_valid + skid_valid.
REQ-029 Data registers MAY hold stale values while their valid bit is 0; only valid bits and out_ctrl gating define visible behaviour.

Reset
REQ-030 rst=1 at an edge SHALL clear main_valid and skid_valid and zero all data, rd and ctrl registers.
REQ-031 After the reset edge: out_valid=0, out_ctrl=0, out_rd=0, out_data=0, occupancy=0, in_ready=1.
REQ-032 rst SHALL take priority over flush, accept and consume; reset in the middle of a transfer discards all entries.

Verification
REQ-033 Streaming: out_ready=1 and in_valid=1 for 8 cycles with in_data=1..8 -> out_data=1..8 on consecutive cycles, each one cycle after input, occupancy=1, in_ready stays 1.
REQ-034 Backpressure: load A; hold out_ready=0 and present B -> B goes to SKID, occupancy=2, in_ready=0; C is held off. Then raise out_ready -> outputs A, B, C in order with no loss.
REQ-035 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the incoming entry is never output.
REQ-036 Bubble gating: in_ctrl=4'b1111 with in_valid=0 -> out_ctrl=0 on every cycle.
REQ-037 rst asserted while in FULL with flush=0 -> after the edge all outputs are zero, occupancy=0, in_ready=1; a later accept of D outputs D.
REQ-038 Parameter sweep: DATA_W=64, CTRL_W=2, RD_W=6 -> random valid/ready traffic against a reference FIFO model shows in-order delivery and no loss.
